// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// A round-robin grant picks one requester in IDLE, its operands are
// registered and presented to the ALU for one EXEC cycle, and the ALU
// result is registered and returned with a one-cycle valid pulse to
// the requester that owns the operation.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting: ready raised for the granted requester
// EXEC  | operand registers drive the ALU; result captured at cycle end
module alu_arbiter #(
  parameter int PRIO_RESET = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_srcA,
  input  logic [31:0] req1_srcA,
  input  logic [31:0] req0_srcB,
  input  logic [31:0] req1_srcB,
  input  logic [2:0]  req0_ctrl,
  input  logic [2:0]  req1_ctrl,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result_in,
  input  logic        alu_zero_in,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_zero
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EXEC = 1'b1;

  // Pointing last_grant at the other requester makes PRIO_RESET win the
  // first contention after reset.
  localparam logic LAST_GRANT_RST = (PRIO_RESET == 0) ? 1'b1 : 1'b0;

  logic        state;
  logic        last_grant;
  logic        owner;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  op_ctrl;

  logic        grant;
  logic        grant_any;
  logic        hs0;
  logic        hs1;

  // Round-robin choice: a lone requester wins, contention goes to the
  // requester that was not served last.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readys are suppressed while rst is high so nothing can be accepted
  // during reset even though the state register already reads IDLE.
  always_comb begin
    req0_ready = (state == ST_IDLE) && !rst && grant_any && (grant == 1'b0);
    req1_ready = (state == ST_IDLE) && !rst && grant_any && (grant == 1'b1);
  end

  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;

  // The ALU only ever sees registered operands, never live request inputs.
  assign alu_srcA    = op_a;
  assign alu_srcB    = op_b;
  assign alu_control = op_ctrl;

  // Sequencer: latch on handshake, run one EXEC cycle, return the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= LAST_GRANT_RST;
      owner      <= 1'b0;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_ctrl    <= 3'd0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs0) begin
            op_a       <= req0_srcA;
            op_b       <= req0_srcB;
            op_ctrl    <= req0_ctrl;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            state      <= ST_EXEC;
          end else if (hs1) begin
            op_a       <= req1_srcA;
            op_b       <= req1_srcB;
            op_ctrl    <= req1_ctrl;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        default: begin
          rsp_result <= alu_result_in;
          rsp_zero   <= alu_zero_in;
          rsp0_valid <= (owner == 1'b0);
          rsp1_valid <= (owner == 1'b1);
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_srcA, req1_srcA, req0_srcB, req1_srcB;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_srcA, alu_srcB;
  logic [2:0]  alu_control;
  logic [31:0] alu_result_in;
  logic        alu_zero_in;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Shared ALU model driven by the arbiter's operand outputs.
  always_comb begin
    case (alu_control)
      OP_AND:  alu_result_in = alu_srcA & alu_srcB;
      OP_OR:   alu_result_in = alu_srcA | alu_srcB;
      OP_ADD:  alu_result_in = alu_srcA + alu_srcB;
      OP_SUB:  alu_result_in = alu_srcA - alu_srcB;
      OP_SLT:  alu_result_in = ($signed(alu_srcA) < $signed(alu_srcB)) ? 32'd1 : 32'd0;
      default: alu_result_in = 32'd0;
    endcase
    alu_zero_in = (alu_result_in == 32'd0);
  end

  alu_arbiter #(.PRIO_RESET(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_srcA(req0_srcA), .req1_srcA(req1_srcA),
    .req0_srcB(req0_srcB), .req1_srcB(req1_srcB),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control),
    .alu_result_in(alu_result_in), .alu_zero_in(alu_zero_in),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_srcA = 32'hDEAD; req0_srcB = 32'hBEEF; req0_ctrl = OP_ADD;
    req1_srcA = 32'h1111; req1_srcB = 32'h2222; req1_ctrl = OP_OR;
    rst = 1'b1;
    tick();
    tick();
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
    else n_pass++;
    n_total++;
    if ({alu_srcA, alu_srcB, alu_control} !== 67'd0) $display("FAIL reset_operands got %h %h %h want 0 0 0", alu_srcA, alu_srcB, alu_control);
    else n_pass++;
    n_total++;
    if ({rsp_result, rsp_zero, rsp0_valid, rsp1_valid} !== 35'd0) $display("FAIL reset_rsp got %h %b %b %b want 0 0 0 0", rsp_result, rsp_zero, rsp0_valid, rsp1_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL first_grant_after_reset got %b want 10", {req0_ready, req1_ready});
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req0_valid = 1'b1; req0_srcA = 32'd5; req0_srcB = 32'd7; req0_ctrl = OP_ADD;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready});
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    #1;
    n_total++;
    if (alu_srcA !== 32'd5 || alu_srcB !== 32'd7 || alu_control !== OP_ADD)
      $display("FAIL single_operands got %0d %0d %b want 5 7 010", alu_srcA, alu_srcB, alu_control);
    else n_pass++;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL single_exec_ready got %b want 00", {req0_ready, req1_ready});
    else n_pass++;
    tick();
    n_total++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd12 || rsp_zero !== 1'b0)
      $display("FAIL single_rsp got v0=%b v1=%b res=%0d z=%b want 1 0 12 0", rsp0_valid, rsp1_valid, rsp_result, rsp_zero);
    else n_pass++;
    tick();
    n_total++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_result !== 32'd12)
      $display("FAIL single_hold got v0=%b v1=%b res=%0d want 0 0 12", rsp0_valid, rsp1_valid, rsp_result);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic exp_owner;
    do_reset();
    req0_valid = 1'b1; req0_srcA = 32'd9;    req0_srcB = 32'd9;    req0_ctrl = OP_SUB;
    req1_valid = 1'b1; req1_srcA = 32'hF0;   req1_srcB = 32'h0F;   req1_ctrl = OP_OR;
    #1;
    exp_owner = 1'b0;
    for (int g = 0; g < 4; g++) begin
      n_total++;
      if ({req0_ready, req1_ready} !== (exp_owner ? 2'b01 : 2'b10))
        $display("FAIL contention_grant%0d got %b want %b", g, {req0_ready, req1_ready}, exp_owner ? 2'b01 : 2'b10);
      else n_pass++;
      tick();
      n_total++;
      if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL contention_exec%0d got %b want 00", g, {req0_ready, req1_ready});
      else n_pass++;
      tick();
      n_total++;
      if (exp_owner == 1'b0) begin
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_zero !== 1'b1)
          $display("FAIL contention_rsp%0d got v0=%b v1=%b res=%h z=%b want 1 0 0 1", g, rsp0_valid, rsp1_valid, rsp_result, rsp_zero);
        else n_pass++;
      end else begin
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b1 || rsp_result !== 32'hFF || rsp_zero !== 1'b0)
          $display("FAIL contention_rsp%0d got v0=%b v1=%b res=%h z=%b want 0 1 ff 0", g, rsp0_valid, rsp1_valid, rsp_result, rsp_zero);
        else n_pass++;
      end
      exp_owner = ~exp_owner;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req1_valid = 1'b1; req1_srcA = 32'hFFFF0000; req1_srcB = 32'h12345678; req1_ctrl = OP_AND;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL b2b_first_ready got %b want 01", {req0_ready, req1_ready});
    else n_pass++;
    tick();
    req1_srcA = 32'd3; req1_srcB = 32'd4; req1_ctrl = OP_SLT;
    tick();
    n_total++;
    if (rsp1_valid !== 1'b1 || rsp_result !== 32'h12340000 || req1_ready !== 1'b1)
      $display("FAIL b2b_first_rsp got v1=%b res=%h rdy1=%b want 1 12340000 1", rsp1_valid, rsp_result, req1_ready);
    else n_pass++;
    tick();
    req1_valid = 1'b0;
    n_total++;
    if (alu_srcA !== 32'd3 || alu_srcB !== 32'd4 || alu_control !== OP_SLT)
      $display("FAIL b2b_second_operands got %0d %0d %b want 3 4 111", alu_srcA, alu_srcB, alu_control);
    else n_pass++;
    tick();
    n_total++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 32'd1 || rsp_zero !== 1'b0)
      $display("FAIL b2b_second_rsp got v1=%b v0=%b res=%h z=%b want 1 0 1 0", rsp1_valid, rsp0_valid, rsp_result, rsp_zero);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_op();
    req0_valid = 1'b1; req0_srcA = 32'd1; req0_srcB = 32'd2; req0_ctrl = OP_ADD;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL midreset_ready got %b want 00", {req0_ready, req1_ready});
    else n_pass++;
    tick();
    n_total++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_result !== 32'd0 || alu_srcA !== 32'd0 || {req0_ready, req1_ready} !== 2'b00)
      $display("FAIL midreset_abort got v0=%b v1=%b res=%h a=%h rdy=%b want 0 0 0 0 00", rsp0_valid, rsp1_valid, rsp_result, alu_srcA, {req0_ready, req1_ready});
    else n_pass++;
    tick();
    n_total++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) $display("FAIL midreset_nopulse got v0=%b v1=%b want 0 0", rsp0_valid, rsp1_valid);
    else n_pass++;
    rst = 1'b0;
    req1_srcA = 32'd10; req1_srcB = 32'd20; req1_ctrl = OP_ADD;
    #1;
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL midreset_new_ready got %b want 01", {req0_ready, req1_ready});
    else n_pass++;
    tick();
    req1_valid = 1'b0;
    tick();
    n_total++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_result !== 32'd30)
      $display("FAIL midreset_new_rsp got v1=%b v0=%b res=%0d want 1 0 30", rsp1_valid, rsp0_valid, rsp_result);
    else n_pass++;
    tick();
  endtask

  task automatic test_operand_stability();
    req0_valid = 1'b1; req0_srcA = 32'd100; req0_srcB = 32'd23; req0_ctrl = OP_ADD;
    tick();
    req0_valid = 1'b0; req0_srcA = 32'd7; req0_srcB = 32'd7; req0_ctrl = OP_SUB;
    #1;
    n_total++;
    if (alu_srcA !== 32'd100 || alu_srcB !== 32'd23 || alu_control !== OP_ADD)
      $display("FAIL stable_operands got %0d %0d %b want 100 23 010", alu_srcA, alu_srcB, alu_control);
    else n_pass++;
    tick();
    n_total++;
    if (rsp0_valid !== 1'b1 || rsp_result !== 32'd123 || rsp_zero !== 1'b0)
      $display("FAIL stable_rsp got v0=%b res=%0d z=%b want 1 123 0", rsp0_valid, rsp_result, rsp_zero);
    else n_pass++;
    tick();
    n_total++;
    if (alu_srcA !== 32'd100 || alu_srcB !== 32'd23 || alu_control !== OP_ADD)
      $display("FAIL idle_hold_operands got %0d %0d %b want 100 23 010", alu_srcA, alu_srcB, alu_control);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_srcA = 32'd0; req0_srcB = 32'd0; req0_ctrl = 3'd0;
    req1_srcA = 32'd0; req1_srcB = 32'd0; req1_ctrl = 3'd0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_reset_mid_op();
    test_operand_stability();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
